cache_req_arbiter: RTL
======================

Name: cache_req_arbiter

Overview:
- Round-robin arbiter sharing the single CPU-side port of the cache controller between two requesters (e.g. CPU core and DMA/debug master).
- Latches the winning request, drives the cache's cs/address/data/wr_rd inputs, holds cs for the cache's capture window, tracks completion via rdy_cpu, and returns a done pulse plus read data to the winner.
- Sits in cache_top, directly upstream of the cache controller.

Parameters:
- ADDR_WIDTH, 16, address width of requesters and cache port
- DATA_WIDTH, 8, data width
- CS_HOLD, 4, cycles cs_cpu is held high per transaction (matches cache capture window)
- TIMEOUT, 255, max cycles waiting on rdy_cpu (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  request level; held until matching done
- addr0 / addr1  in  ADDR_WIDTH  request address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- wr_rd0 / wr_rd1  in  1  1 = write, 0 = read
- gnt0 / gnt1  out  1  high from grant through done
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  DATA_WIDTH  read data, valid in the done cycle
- Address_cpu  out  ADDR_WIDTH  to cache
- DOut_cpu  out  DATA_WIDTH  to cache
- wr_rd_cpu  out  1  to cache
- cs_cpu  out  1  to cache
- rdy_cpu  in  1  cache ready (low while busy)
- DIn_cache  in  DATA_WIDTH  cache read data
- err  out  1  timeout pulse (0 unless ARB_TIMEOUT_EN)

Behaviour:
- Reset: state IDLE; all outputs 0; last_gnt = 1 (so req0 wins the first tie); hold counter 0.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE.
- IDLE: if req0|req1, grant in the next cycle.
  - Only one request: grant it.
  - Both requesting: grant !last_gnt.
  - On grant: latch addr/wdata/wr_rd into the Address_cpu/DOut_cpu/wr_rd_cpu registers; set gnt; last_gnt <= winner; go to ISSUE.
- ISSUE: cs_cpu = 1 for exactly CS_HOLD cycles (counter 0..CS_HOLD-1), then cs_cpu = 0 and go to WAIT_BUSY.
  - Cache outputs stay stable throughout ISSUE and until DONE.
- WAIT_BUSY: wait for rdy_cpu = 0, then go to WAIT_DONE.
  - A transaction that completes with no visible low (rdy already high for 2 consecutive cycles after cs drop, i.e. a fast hit) also goes to DONE.
- WAIT_DONE: on rdy_cpu rising to 1, capture DIn_cache into rdata (read only; rdata unchanged on write) and go to DONE.
- DONE: done<winner> = 1 for one cycle; gnt drops in the same cycle; return to IDLE.
  - New arbitration happens in IDLE on the next cycle, giving a one-cycle minimum gap between transactions.
- Requests are sampled only in IDLE. Request deassertion mid-transaction is ignored; the transaction completes.
- Grant output is registered: at most one of gnt0/gnt1 is ever high, and done0/done1 are never simultaneous.
- Reset mid-operation: immediate return to IDLE with all outputs 0; no done is issued.
- CS_HOLD of 0 is illegal; use the 2-bit minimum counter width: $clog2(CS_HOLD+1).

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent in WAIT_BUSY + WAIT_DONE.
  - Reaching TIMEOUT: err pulses 1 cycle, done<winner> pulses with rdata = 0, then IDLE.
- Undefined: no counter is present, err is tied 0, and the arbiter waits indefinitely.

Decomposition:
- Shared package: state encoding constants (IDLE=0 … DONE=4, 3-bit, matching the width of cache_fsm's current_state), CS_HOLD default, WR/RD encoding constants.
- One sub-module is natural: rr_arb2, a combinational two-input round-robin picker (inputs req[1:0] and last_gnt, output winner and valid).

Test Plan:
- Single read: req0=1, addr0=16'h1234, wr_rd0=0; cache model holds rdy low 10 cycles, returns 8'hA5 -> cs_cpu high exactly 4 cycles, Address_cpu=16'h1234, done0 pulse, rdata=8'hA5.
- Simultaneous requests after reset: req0 and req1 asserted together -> gnt0 first; after done0, gnt1 in IDLE+1; a second tie grants req0 again (alternation).
- Write pass-through: req1 write, addr 16'h00FF, wdata 8'h3C -> DOut_cpu=8'h3C, wr_rd_cpu=1 during ISSUE, done1 pulse, rdata unchanged.
- Fast hit: rdy_cpu never drops -> DONE reached 2 cycles after cs drop, done pulse issued.
- Reset in WAIT_DONE: rst asserted -> cs_cpu, gnt, done all 0 next edge; a req held after reset is re-granted cleanly.
- ARB_TIMEOUT_EN: rdy_cpu held low forever with TIMEOUT=16 -> err and done pulse together 16 cycles after WAIT_BUSY entry, rdata=0.

Source files
------------

// File: rtl/cache_req_arbiter_pkg.sv
// Shared definitions for the cache request arbiter.
//   - arb_state_t : FSM encoding, 3 bits wide so it lines up with the cache
//                   controller's own state register when both are probed.
//   - CS_HOLD_DEFAULT : default number of cycles cs_cpu stays high.
//   - WR / RD : encoding of the wr_rd request/cache signals.
//   - hold_cnt_width() : width of the cs hold counter (never below 2 bits).
package cache_req_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } arb_state_t;

  localparam int CS_HOLD_DEFAULT = 4;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  function automatic int hold_cnt_width(input int hold);
    return ($clog2(hold + 1) < 2) ? 2 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/cache_req_arbiter_rr.sv
// rr_arb2: combinational two-input round-robin picker.
// Ports:
//   req[1:0]  in   request vector (bit i = requester i)
//   last_gnt  in   index of the requester that won most recently
//   winner    out  index of the chosen requester (meaningful when valid)
//   valid     out  at least one request is present
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      // Contention: hand the port to whoever did not win last time.
      2'b11:   winner = ~last_gnt;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: shares the single CPU-side port of the cache controller
// between two requesters using round-robin arbitration.
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog on the wait for
// rdy_cpu; without it err is tied low and the arbiter waits indefinitely.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req0/1, addr0/1, wdata0/1,
//   wr_rd0/1                        requester side (req held until done)
//   gnt0/1                          high from grant until the done cycle
//   done0/1                         one-cycle completion pulse
//   rdata                           read data, valid in the done cycle
//   Address_cpu, DOut_cpu,
//   wr_rd_cpu, cs_cpu               registered drive of the cache port
//   rdy_cpu, DIn_cache              cache ready (low while busy) and data
//   err                             watchdog expiry pulse
module cache_req_arbiter
  import cache_req_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CS_HOLD    = CS_HOLD_DEFAULT,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  wr_rd0,
  input  logic                  wr_rd1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] Address_cpu,
  output logic [DATA_WIDTH-1:0] DOut_cpu,
  output logic                  wr_rd_cpu,
  output logic                  cs_cpu,
  input  logic                  rdy_cpu,
  input  logic [DATA_WIDTH-1:0] DIn_cache,
  output logic                  err
);

  localparam int                HOLD_W    = hold_cnt_width(CS_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

  // A zero-length cs window would never be captured by the cache.
  if (CS_HOLD < 1 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_params
    $error("cache_req_arbiter: CS_HOLD must be >= 1 and TIMEOUT within 1..255");
  end

  arb_state_t        state;
  arb_state_t        state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hi_seen;   // rdy_cpu was high in the previous WAIT_BUSY cycle
  logic              last_gnt;
  logic              win;       // index of the requester owning the transaction
  logic              pick_winner;
  logic              pick_valid;
  logic              expire;
  logic              wd_hit;

  rr_arb2 u_pick (
    .req      ({req1, req0}),
    .last_gnt (last_gnt),
    .winner   (pick_winner),
    .valid    (pick_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wd_cnt;
  logic       err_reg;

  assign wd_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) && (wd_cnt == WD_LAST);

  // Counts every cycle spent waiting on the cache; cleared outside the wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt  <= '0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= expire;
      if ((state == WAIT_BUSY) || (state == WAIT_DONE)) wd_cnt <= wd_cnt + 8'd1;
      else                                              wd_cnt <= '0;
    end
  end

  assign err = err_reg;
`else
  assign wd_hit = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    expire     = 1'b0;
    case (state)
      IDLE:      if (pick_valid) state_next = ISSUE;
      ISSUE:     if (hold_cnt == HOLD_LAST) state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!rdy_cpu)     state_next = WAIT_DONE;
        // Two consecutive high cycles after cs drops: a hit that never went busy.
        else if (hi_seen) state_next = DONE;
      end
      WAIT_DONE: if (rdy_cpu) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    // A genuine completion in the expiry cycle takes precedence.
    if (wd_hit && (state_next != DONE)) begin
      state_next = DONE;
      expire     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt    <= '0;
      hi_seen     <= 1'b0;
      last_gnt    <= 1'b1;
      win         <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      rdata       <= '0;
      Address_cpu <= '0;
      DOut_cpu    <= '0;
      wr_rd_cpu   <= 1'b0;
      cs_cpu      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            win         <= pick_winner;
            last_gnt    <= pick_winner;
            gnt0        <= ~pick_winner;
            gnt1        <= pick_winner;
            Address_cpu <= pick_winner ? addr1 : addr0;
            DOut_cpu    <= pick_winner ? wdata1 : wdata0;
            wr_rd_cpu   <= pick_winner ? wr_rd1 : wr_rd0;
            cs_cpu      <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        ISSUE: begin
          if (hold_cnt == HOLD_LAST) begin
            cs_cpu  <= 1'b0;
            hi_seen <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        WAIT_BUSY: hi_seen <= rdy_cpu;
        default: ;
      endcase

      if (state_next == DONE) begin
        gnt0  <= 1'b0;
        gnt1  <= 1'b0;
        done0 <= ~win;
        done1 <= win;
        if (expire)               rdata <= '0;
        else if (wr_rd_cpu == RD) rdata <= DIn_cache;
      end

      if (state == DONE) begin
        done0 <= 1'b0;
        done1 <= 1'b0;
      end
    end
  end

endmodule
